// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: ID-stage request inputs and per-stage control/hazard outputs of pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
  parameter int OPCODE_W = 7,
  parameter int REG_AW = 5,
  parameter int ALUOP_W = 2
);
  logic id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic ex_branch_taken;
  logic stall;
  logic flush;
  logic illegal_op;
  logic ex_alusrc;
  logic ex_branch;
  logic [ALUOP_W-1:0] ex_aluop;
  logic mem_memread;
  logic mem_memwrite;
  logic wb_regwrite;
  logic wb_memtoreg;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input stall, flush, illegal_op, ex_alusrc, ex_branch, ex_aluop, mem_memread, mem_memwrite,
    input wb_regwrite, wb_memtoreg, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b
  );
  modport slave (
    input id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall, flush, illegal_op, ex_alusrc, ex_branch, ex_aluop, mem_memread, mem_memwrite,
    output wb_regwrite, wb_memtoreg, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32 5-stage control decode, EX/MEM/WB control registers, stall/flush and forwarding selects.
// Define PIPE_CTRL_FWD_EN for operand forwarding; otherwise RAW hazards stall until the producer reaches WB.
module pipe_ctrl_unit #(
  parameter int OPCODE_W = 7,
  parameter int REG_AW = 5,
  parameter int ALUOP_W = 2
) (
  input logic clk,
  input logic rst_n,
  pipe_ctrl_unit_if.slave bus
);
  localparam logic [OPCODE_W-1:0] OP_R = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LD = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_ST = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BR = 7'b1100011;
  typedef struct packed {
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;
  ctrl_t dec, idCtrl, exCtrl;
  logic hit, rs2Used, live, useRs1, useRs2;
  logic exMatch, memMatch, hazard, flushNow, bubble;
  logic memRead, memWrite, memRegwrite, memMemtoreg, wbRegwrite, wbMemtoreg;
  logic [REG_AW-1:0] exRd, memRd, wbRd;
  always_comb begin
    dec = '0;
    rs2Used = 1'b0;
    hit = 1'b1;
    case (bus.id_opcode)
      OP_R: begin dec = 8'b0010_0010; rs2Used = 1'b1; end
      OP_I: dec = 8'b1010_0010;
      OP_LD: dec = 8'b1111_0000;
      OP_ST: begin dec = 8'b1000_1000; rs2Used = 1'b1; end
      OP_BR: begin dec = 8'b0000_0101; rs2Used = 1'b1; end
      default: hit = 1'b0;
    endcase
  end
  assign live = bus.id_valid & hit;
  assign useRs1 = live;
  assign useRs2 = live & rs2Used;
  assign bus.illegal_op = bus.id_valid & ~hit;
  always_comb begin
    idCtrl = live ? dec : '0;
    idCtrl.regwrite = idCtrl.regwrite & (bus.id_rd != '0);
  end
  assign exMatch = (exRd != '0) & ((useRs1 & (exRd == bus.id_rs1)) | (useRs2 & (exRd == bus.id_rs2)));
  assign memMatch = (memRd != '0) & ((useRs1 & (memRd == bus.id_rs1)) | (useRs2 & (memRd == bus.id_rs2)));
  assign flushNow = exCtrl.branch & bus.ex_branch_taken;
`ifdef PIPE_CTRL_FWD_EN
  logic [REG_AW-1:0] exRs1, exRs2;
  assign hazard = exCtrl.memread & exMatch;
  // sources are zeroed when unused so x0 or garbage fields never select a bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exRs1 <= '0;
      exRs2 <= '0;
    end else begin
      exRs1 <= (bubble | ~useRs1) ? '0 : bus.id_rs1;
      exRs2 <= (bubble | ~useRs2) ? '0 : bus.id_rs2;
    end
  end
  assign bus.fwd_a = (memRegwrite && memRd != '0 && memRd == exRs1) ? 2'b10 :
                     (wbRegwrite && wbRd == exRs1) ? 2'b01 : 2'b00;
  assign bus.fwd_b = (memRegwrite && memRd != '0 && memRd == exRs2) ? 2'b10 :
                     (wbRegwrite && wbRd == exRs2) ? 2'b01 : 2'b00;
`else
  assign hazard = (exCtrl.regwrite & exMatch) | (memRegwrite & memMatch);
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif
  assign bus.flush = flushNow;
  assign bus.stall = hazard & ~flushNow;
  assign bubble = flushNow | hazard;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exCtrl <= '0;
      exRd <= '0;
      memRead <= 1'b0;
      memWrite <= 1'b0;
      memRegwrite <= 1'b0;
      memMemtoreg <= 1'b0;
      memRd <= '0;
      wbRegwrite <= 1'b0;
      wbMemtoreg <= 1'b0;
      wbRd <= '0;
    end else begin
      exCtrl <= bubble ? '0 : idCtrl;
      exRd <= (bubble | ~live) ? '0 : bus.id_rd;
      memRead <= exCtrl.memread;
      memWrite <= exCtrl.memwrite;
      memRegwrite <= exCtrl.regwrite;
      memMemtoreg <= exCtrl.memtoreg;
      memRd <= exRd;
      wbRegwrite <= memRegwrite;
      wbMemtoreg <= memMemtoreg;
      wbRd <= memRd;
    end
  end
  assign bus.ex_alusrc = exCtrl.alusrc;
  assign bus.ex_branch = exCtrl.branch;
  assign bus.ex_aluop = exCtrl.aluop;
  assign bus.ex_rd = exRd;
  assign bus.mem_memread = memRead;
  assign bus.mem_memwrite = memWrite;
  assign bus.mem_rd = memRd;
  assign bus.wb_regwrite = wbRegwrite;
  assign bus.wb_memtoreg = wbMemtoreg;
  assign bus.wb_rd = wbRd;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: decode table sweep plus hazard/flush/forwarding/reset sequences against a stage-shift scoreboard.
module tb_pipe_ctrl_unit;
  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_L = 7'b0000011, O_S = 7'b0100011, O_B = 7'b1100011;
  localparam logic [7:0] W_R = 8'b0010_0010, W_I = 8'b1010_0010, W_L = 8'b1111_0000, W_S = 8'b1000_1000, W_B = 8'b0000_0101;
  typedef struct packed {logic [7:0] w; logic [4:0] rd;} exp_t;
  typedef struct {logic [6:0] op; logic [7:0] w; logic ill;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t exE = '0, memE = '0, wbE = '0;
  pipe_ctrl_unit_if bus ();
  pipe_ctrl_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic exp_t mk(input logic [7:0] w, input logic [4:0] rd);
    return {w, rd};
  endfunction
  function automatic logic [31:0] outs();
    return {bus.stall, bus.flush, bus.ex_alusrc, bus.ex_branch, bus.ex_aluop, bus.ex_rd,
            bus.mem_memread, bus.mem_memwrite, bus.mem_rd, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd,
            bus.fwd_a, bus.fwd_b};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask
  task automatic post(input string nm, input logic [3:0] fw);
    exp_t e;
    @(posedge clk);
    #1;
    e = '0;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else e = q.pop_front();
    wbE = memE;
    memE = exE;
    exE = e;
    chk({nm, " ex"}, {bus.ex_alusrc, bus.ex_branch, bus.ex_aluop, bus.ex_rd}, {exE.w[7], exE.w[2], exE.w[1:0], exE.rd});
    chk({nm, " mem"}, {bus.mem_memread, bus.mem_memwrite, bus.mem_rd}, {memE.w[4], memE.w[3], memE.rd});
    chk({nm, " wb"}, {bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}, {wbE.w[5], wbE.w[6], wbE.rd});
    chk({nm, " fwd"}, {bus.fwd_a, bus.fwd_b}, fw);
  endtask
  task automatic cyc(input string nm, input logic v, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic tk, input logic [2:0] pre, input exp_t nx, input logic [3:0] fw);
    bus.id_valid = v;
    bus.id_opcode = op;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_rd = rd;
    bus.ex_branch_taken = tk;
    #1;
    chk({nm, " stall/flush/ill"}, {bus.stall, bus.flush, bus.illegal_op}, pre);
    q.push_back(nx);
    post(nm, fw);
  endtask
  task automatic nop(input string nm);
    cyc(nm, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, '0, 4'b0000);
  endtask
  initial begin
    vec_t tbl [6];
    tbl[0] = '{O_R, W_R, 1'b0};
    tbl[1] = '{O_I, W_I, 1'b0};
    tbl[2] = '{O_L, W_L, 1'b0};
    tbl[3] = '{O_S, W_S, 1'b0};
    tbl[4] = '{O_B, W_B, 1'b0};
    tbl[5] = '{7'b1111111, 8'd0, 1'b1};
    bus.id_valid = 1'b0;
    bus.id_opcode = '0;
    bus.id_rs1 = '0;
    bus.id_rs2 = '0;
    bus.id_rd = '0;
    bus.ex_branch_taken = 1'b0;
    #12;
    chk("reset", outs(), 32'd0);
    rst_n = 1'b1;
    foreach (tbl[i])
      cyc($sformatf("dec%0d", i), 1'b1, tbl[i].op, 5'd1, 5'd2, 5'd5, 1'b0, {2'b00, tbl[i].ill},
          tbl[i].ill ? '0 : mk(tbl[i].w, 5'd5), 4'b0000);
    for (int i = 0; i < 3; i++) nop("drain");
    cyc("lw", 1'b1, O_L, 5'd1, 5'd0, 5'd5, 1'b0, 3'b000, mk(W_L, 5'd5), 4'b0000);
    cyc("lu_stall", 1'b1, O_R, 5'd5, 5'd7, 5'd6, 1'b0, 3'b100, '0, 4'b0000);
`ifdef PIPE_CTRL_FWD_EN
    cyc("lu_add", 1'b1, O_R, 5'd5, 5'd7, 5'd6, 1'b0, 3'b000, mk(W_R, 5'd6), 4'b0100);
    cyc("b2b_add", 1'b1, O_R, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, mk(W_R, 5'd3), 4'b0000);
    cyc("b2b_sub", 1'b1, O_R, 5'd3, 5'd3, 5'd4, 1'b0, 3'b000, mk(W_R, 5'd4), 4'b1010);
    cyc("b2b_and", 1'b1, O_R, 5'd4, 5'd3, 5'd9, 1'b0, 3'b000, mk(W_R, 5'd9), 4'b1001);
    cyc("pri_add1", 1'b1, O_R, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, mk(W_R, 5'd3), 4'b0000);
    cyc("pri_add2", 1'b1, O_R, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, mk(W_R, 5'd3), 4'b0000);
    cyc("pri_or", 1'b1, O_R, 5'd3, 5'd0, 5'd10, 1'b0, 3'b000, mk(W_R, 5'd10), 4'b1000);
`else
    cyc("lu_stall2", 1'b1, O_R, 5'd5, 5'd7, 5'd6, 1'b0, 3'b100, '0, 4'b0000);
    cyc("lu_add", 1'b1, O_R, 5'd5, 5'd7, 5'd6, 1'b0, 3'b000, mk(W_R, 5'd6), 4'b0000);
    cyc("b2b_add", 1'b1, O_R, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, mk(W_R, 5'd3), 4'b0000);
    cyc("b2b_stall1", 1'b1, O_R, 5'd3, 5'd3, 5'd4, 1'b0, 3'b100, '0, 4'b0000);
    cyc("b2b_stall2", 1'b1, O_R, 5'd3, 5'd3, 5'd4, 1'b0, 3'b100, '0, 4'b0000);
    cyc("b2b_sub", 1'b1, O_R, 5'd3, 5'd3, 5'd4, 1'b0, 3'b000, mk(W_R, 5'd4), 4'b0000);
`endif
    for (int i = 0; i < 3; i++) nop("drain");
    cyc("br_lw", 1'b1, O_L, 5'd1, 5'd0, 5'd5, 1'b0, 3'b000, mk(W_L, 5'd5), 4'b0000);
    cyc("br_beq", 1'b1, O_B, 5'd1, 5'd2, 5'd0, 1'b0, 3'b000, mk(W_B, 5'd0), 4'b0000);
    cyc("br_flush", 1'b1, O_R, 5'd5, 5'd5, 5'd6, 1'b1, 3'b010, '0, 4'b0000);
    cyc("tk_nobr", 1'b1, O_R, 5'd1, 5'd2, 5'd7, 1'b1, 3'b000, mk(W_R, 5'd7), 4'b0000);
    cyc("x0_addi", 1'b1, O_I, 5'd1, 5'd0, 5'd0, 1'b0, 3'b000, mk(8'b1000_0010, 5'd0), 4'b0000);
    cyc("x0_add", 1'b1, O_R, 5'd0, 5'd0, 5'd1, 1'b0, 3'b000, mk(W_R, 5'd1), 4'b0000);
    nop("x0_n1");
    nop("x0_n2");
    cyc("rs_lw", 1'b1, O_L, 5'd2, 5'd0, 5'd8, 1'b0, 3'b000, mk(W_L, 5'd8), 4'b0000);
    nop("rs_n1");
    bus.id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", outs(), 32'd0);
    rst_n = 1'b1;
    q.delete();
    exE = '0;
    memE = '0;
    wbE = '0;
    cyc("refill_lw", 1'b1, O_L, 5'd2, 5'd0, 5'd8, 1'b0, 3'b000, mk(W_L, 5'd8), 4'b0000);
    nop("refill_n1");
    nop("refill_n2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
